// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the asynchronous FIFO and its read-side packer.
package async_fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;

  localparam logic [1:0] KEEP_FULL = 2'b11;
  localparam logic [1:0] KEEP_HALF = 2'b01;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/async_fifo_rd_packer_if.sv
// Valid/ready stream carrying packed 2*DSIZE beats with a per-lane keep mask.
interface async_fifo_rd_packer_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF
);

  logic               valid;
  logic               ready;
  logic [2*DSIZE-1:0] data;
  logic [1:0]         keep;

  modport master (output valid, output data, output keep, input ready);
  modport slave  (input valid, input data, input keep, output ready);

endinterface

// File: rtl/async_fifo_rd_packer_out_buf.sv
// Two-entry registered valid/ready buffer; head entry drives the output directly.
module rd_out_buf2 #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   cnt
);

  logic [W-1:0] slot1_q;
  logic         enq_c;
  logic         deq_c;

  // Writes are dropped when full; the parent only offers data when space exists.
  always_comb begin
    enq_c = in_valid && (cnt != 2'd2);
    deq_c = out_valid && out_ready;
  end

  // Occupancy, head (output) and second-entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      slot1_q   <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (enq_c) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            cnt       <= 2'd1;
          end
        end
        2'd1: begin
          if (enq_c && deq_c) begin
            out_data <= in_data;
          end else if (enq_c) begin
            slot1_q <= in_data;
            cnt     <= 2'd2;
          end else if (deq_c) begin
            out_valid <= 1'b0;
            cnt       <= 2'd0;
          end
        end
        2'd2: begin
          if (deq_c) begin
            out_data <= slot1_q;
            cnt      <= 2'd1;
          end
        end
        default: begin
          cnt       <= 2'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/async_fifo_rd_packer.sv
// Read-side FIFO consumer: pops words, packs pairs into double-width beats and
// flushes a lone trailing word as a half beat after an idle timeout.
module async_fifo_rd_packer
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE   = DSIZE_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  async_fifo_rd_packer_if.master m
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned PW = 2 * DSIZE + 2;
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  pack_state_t      state_q, state_d;
  logic [DSIZE-1:0] lo_q, lo_d;
  logic [CW-1:0]    idle_q, idle_d;
  logic             run_q;
  logic             space_c;
  logic             expired_c;
  logic             enq_c;
  logic [PW-1:0]    enq_data_c;
  logic [PW-1:0]    buf_data;
  logic [1:0]       buf_cnt;

  // Flush fires on the edge where the idle count would reach TIMEOUT.
  always_comb begin
    space_c   = (buf_cnt != 2'd2);
    expired_c = (TIMEOUT != 0) && (idle_q >= TO_LAST);
  end

  // Pack FSM next state, pop strobe and buffer enqueue.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    idle_d     = idle_q;
    enq_c      = 1'b0;
    enq_data_c = '0;
    rinc       = run_q && !rempty && ((state_q == EMPTY) || space_c);
    case (state_q)
      EMPTY: begin
        idle_d = '0;
        if (rinc) begin
          lo_d    = rdata;
          state_d = HALF;
        end
      end
      HALF: begin
        if (rinc) begin
          enq_c      = 1'b1;
          enq_data_c = {KEEP_FULL, rdata, lo_q};
          state_d    = EMPTY;
          idle_d     = '0;
        end else if (rempty && (TIMEOUT != 0)) begin
          if (expired_c && space_c) begin
            enq_c      = 1'b1;
            enq_data_c = {KEEP_HALF, {DSIZE{1'b0}}, lo_q};
            state_d    = EMPTY;
            idle_d     = '0;
          end else if (idle_q != TO_MAX) begin
            idle_d = idle_q + CW'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Pack state; run_q holds off popping for the first cycle after reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= EMPTY;
      lo_q    <= '0;
      idle_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      idle_q  <= idle_d;
      run_q   <= 1'b1;
    end
  end

  rd_out_buf2 #(
    .W (PW)
  ) u_buf (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .in_valid  (enq_c),
    .in_data   (enq_data_c),
    .out_valid (m.valid),
    .out_data  (buf_data),
    .out_ready (m.ready),
    .cnt       (buf_cnt)
  );

  // Split buffered payload into keep mask and data lanes.
  always_comb begin
    m.keep = buf_data[PW-1 -: 2];
    m.data = buf_data[2*DSIZE-1:0];
  end

endmodule

// File: tb/tb_async_fifo_rd_packer.sv
// Directed bench for async_fifo_rd_packer: packing, flush, race, backpressure, reset.
module tb_async_fifo_rd_packer;
  import async_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic       rempty, rempty0;
  logic [7:0] rdata, rdata0;
  logic       rinc, rinc0;

  async_fifo_rd_packer_if #(.DSIZE(8)) mif  ();
  async_fifo_rd_packer_if #(.DSIZE(8)) mif0 ();

  async_fifo_rd_packer #(.DSIZE(8), .TIMEOUT(16)) dut (
    .rclk(clk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc), .m(mif)
  );

  async_fifo_rd_packer #(.DSIZE(8), .TIMEOUT(0)) dut0 (
    .rclk(clk), .rrst_n(rrst_n), .rempty(rempty0), .rdata(rdata0), .rinc(rinc0), .m(mif0)
  );

  always #5 clk = ~clk;

  logic [7:0]  fifo_q[$];
  logic [17:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  logic pop0_last = 1'b0;

  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endtask

  // One clock: sample pre-edge handshakes, model the FIFO pop, record accepted beats.
  task automatic tick();
    logic        pop_s, acc_s, pop0_s;
    logic [17:0] beat_s;
    #1;
    pop_s  = rinc;
    pop0_s = rinc0;
    acc_s  = mif.valid & mif.ready;
    beat_s = {mif.keep, mif.data};
    checks++;
    if (rempty === 1'b1 && rinc !== 1'b0) begin
      errors++;
      $display("FAIL rinc_while_empty: rinc=%b required 0 (cycle %0d)", rinc, cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s) begin
      void'(fifo_q.pop_front());
      pops++;
      last_pop_cyc = cyc;
    end
    if (acc_s) got_q.push_back(beat_s);
    pop0_last = pop0_s;
    drive_fifo();
    #1;
  endtask

  task automatic test_reset();
    rrst_n     = 1'b0;
    mif.ready  = 1'b0;
    mif0.ready = 1'b1;
    rempty0    = 1'b1;
    rdata0     = 8'h00;
    fifo_q     = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_fifo();
    #2;
    checks++;
    if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b required 0", rinc); end
    checks++;
    if (mif.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", mif.valid); end
    checks++;
    if (mif.data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h required 0000", mif.data); end
    checks++;
    if (mif.keep !== 2'b00) begin errors++; $display("FAIL reset_keep: got %b required 00", mif.keep); end
    tick();
    tick();
    rrst_n = 1'b1;
  endtask

  task automatic test_pack();
    int  first_cyc;
    bit  lat_done;
    first_cyc = -1;
    lat_done  = 1'b0;
    mif.ready = 1'b1;
    pops = 0;
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pops == 1 && first_cyc < 0) first_cyc = cyc;
      if (pops == 2 && !lat_done) begin
        lat_done = 1'b1;
        checks++;
        if (mif.valid !== 1'b1 || mif.data !== 16'h2211) begin
          errors++;
          $display("FAIL pack_latency: valid=%b data=%h required 1/2211", mif.valid, mif.data);
        end
      end
    end
    checks++;
    if (pops != 4) begin errors++; $display("FAIL pack_pops: got %0d required 4", pops); end
    checks++;
    if (last_pop_cyc - first_cyc != 3) begin
      errors++;
      $display("FAIL pack_throughput: pop span %0d required 3", last_pop_cyc - first_cyc);
    end
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL pack_count: got %0d beats required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {2'b11, 16'h2211}) begin errors++; $display("FAIL pack_beat0: got %h required 32211", got_q[0]); end
      checks++;
      if (got_q[1] !== {2'b11, 16'h4433}) begin errors++; $display("FAIL pack_beat1: got %h required 34433", got_q[1]); end
    end
  endtask

  task automatic test_flush();
    bit early;
    early = 1'b0;
    got_q.delete();
    pops = 0;
    fifo_q.push_back(8'hA5);
    drive_fifo();
    tick();
    checks++;
    if (pops != 1) begin errors++; $display("FAIL flush_pop: got %0d pops required 1", pops); end
    for (int k = 1; k < 16; k++) begin
      tick();
      if (mif.valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL flush_early: valid seen before 16 cycles, required none"); end
    tick();
    checks++;
    if (mif.valid !== 1'b1 || mif.data !== 16'h00A5 || mif.keep !== 2'b01) begin
      errors++;
      $display("FAIL flush_beat: valid=%b data=%h keep=%b required 1/00a5/01", mif.valid, mif.data, mif.keep);
    end
    checks++;
    if (dut.state_q !== EMPTY) begin errors++; $display("FAIL flush_state: got %0d required EMPTY", dut.state_q); end
    tick();
    tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'b01, 16'h00A5}) begin
      errors++;
      $display("FAIL flush_accept: got %0d beats, first %h required 1 beat 100a5", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 18'h0);
    end
  endtask

  task automatic test_race();
    got_q.delete();
    pops = 0;
    fifo_q.push_back(8'h01);
    drive_fifo();
    tick();
    for (int k = 0; k < 15; k++) tick();
    fifo_q.push_back(8'h02);
    drive_fifo();
    tick();
    checks++;
    if (pops != 2) begin errors++; $display("FAIL race_pops: got %0d required 2", pops); end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'b11, 16'h0201}) begin
      errors++;
      $display("FAIL race_beat: got %0d beats, first %h required 1 beat 30201", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 18'h0);
    end
  endtask

  task automatic test_backpressure();
    bit          stable;
    logic [15:0] held;
    stable    = 1'b1;
    mif.ready = 1'b0;
    got_q.delete();
    pops = 0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h30 + i));
    drive_fifo();
    tick();
    tick();
    tick();
    held = mif.data;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (mif.valid !== 1'b1 || mif.data !== held) stable = 1'b0;
    end
    checks++;
    if (pops != 5) begin errors++; $display("FAIL bp_pops: got %0d required 5", pops); end
    checks++;
    if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc: got %b required 0", rinc); end
    checks++;
    if (dut.u_buf.cnt !== 2'd2) begin errors++; $display("FAIL bp_cnt: got %0d required 2", dut.u_buf.cnt); end
    checks++;
    if (mif.data !== 16'h3130) begin errors++; $display("FAIL bp_head: got %h required 3130", mif.data); end
    checks++;
    if (!stable) begin errors++; $display("FAIL bp_stable: head changed while stalled, required stable"); end
    mif.ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d beats required 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [17:0] exp_beat;
        exp_beat = {2'b11, 8'(8'h31 + 2 * i), 8'(8'h30 + 2 * i)};
        checks++;
        if (got_q[i] !== exp_beat) begin
          errors++;
          $display("FAIL bp_beat%0d: got %h required %h", i, got_q[i], exp_beat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    mif.ready = 1'b0;
    got_q.delete();
    pops = 0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h40 + i));
    drive_fifo();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (pops != 5 || dut.state_q !== HALF || dut.u_buf.cnt !== 2'd2) begin
      errors++;
      $display("FAIL rst_setup: pops=%0d state=%0d cnt=%0d required 5/HALF/2", pops, dut.state_q, dut.u_buf.cnt);
    end
    #2;
    rrst_n = 1'b0;
    #1;
    checks++;
    if (mif.valid !== 1'b0 || mif.keep !== 2'b00) begin
      errors++;
      $display("FAIL rst_async: valid=%b keep=%b required 0/00", mif.valid, mif.keep);
    end
    tick();
    rrst_n    = 1'b1;
    mif.ready = 1'b1;
    fifo_q.push_back(8'h46);
    drive_fifo();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {2'b11, 16'h4645}) begin
      errors++;
      $display("FAIL rst_first_beat: got %0d beats, first %h required 1 beat 34645", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 18'h0);
    end
    checks++;
    if (fifo_q.size() != 0) begin errors++; $display("FAIL rst_fifo_left: got %0d words required 0", fifo_q.size()); end
  endtask

  task automatic test_timeout0();
    bit saw;
    saw     = 1'b0;
    rempty0 = 1'b0;
    rdata0  = 8'h77;
    tick();
    rempty0 = 1'b1;
    checks++;
    if (pop0_last !== 1'b1) begin errors++; $display("FAIL t0_pop1: got %b required 1", pop0_last); end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mif0.valid !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin errors++; $display("FAIL t0_noflush: beat seen, required none"); end
    rempty0 = 1'b0;
    rdata0  = 8'h88;
    tick();
    rempty0 = 1'b1;
    checks++;
    if (pop0_last !== 1'b1) begin errors++; $display("FAIL t0_pop2: got %b required 1", pop0_last); end
    checks++;
    if (mif0.valid !== 1'b1 || mif0.data !== 16'h8877 || mif0.keep !== 2'b11) begin
      errors++;
      $display("FAIL t0_beat: valid=%b data=%h keep=%b required 1/8877/11", mif0.valid, mif0.data, mif0.keep);
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush();
    test_race();
    test_backpressure();
    test_reset_mid();
    test_timeout0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
